pipe_run_ctrl: RTL and testbench
================================

PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

Interface
REQ-001 SHALL have parameter IMEM_AW, default 9, meaning the instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the program-word width.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  meaning the reset; reset is synchronous and active-high.
REQ-005 SHALL have port start  in  1  meaning a one-cycle request to begin a load/run sequence.
REQ-006 SHALL have port abort  in  1  meaning a one-cycle request to terminate the sequence.
REQ-007 SHALL have port prog_len  in  IMEM_AW+1  meaning the number of program words to load.
REQ-008 SHALL have port run_cycles  in  32  meaning the number of cycles pipe_en is held high.
REQ-009 SHALL have ports ld_valid in 1, ld_data in DATA_W, and ld_ready out 1, forming the program-word stream handshake.
REQ-010 SHALL have ports pipe_reset out 1 and pipe_en out 1, which drive the pipeline reset and enable.
REQ-011 SHALL have ports imem_we out 1, imem_addr out IMEM_AW, and imem_data out DATA_W, which form the instruction-memory write port.
REQ-012 SHALL have ports busy out 1, done out 1, state out 3, and cycles_run out 32, which provide status for the hardware registers.

Function
REQ-013 SHALL implement the following states, each with its encoding on the state output:
- IDLE=0
- CLR=1
- LOAD=2
- RUN=3
- DONE=4
REQ-014 SHALL, in IDLE or DONE, on start=1, latch prog_len (clamped to 2^IMEM_AW) and run_cycles, clear cycles_run and done, and enter CLR next cycle.
REQ-015 SHALL ignore start while in CLR, LOAD, or RUN.
REQ-016 SHALL assert pipe_reset for exactly 2 cycles in CLR and deassert it in all other states.
REQ-017 SHALL exit CLR as follows:
- to LOAD if the latched length is nonzero;
- else to RUN if the latched run_cycles is nonzero;
- else to DONE.
REQ-018 SHALL drive ld_ready=1 only in LOAD while the loaded word count is below the latched length.
REQ-019 SHALL, for each LOAD-cycle handshake (ld_valid & ld_ready), assert imem_we on the next cycle with imem_data=ld_data and imem_addr=word index, starting at 0.
REQ-020 SHALL increment the word index by 1 per handshake and issue no imem write on cycles without a handshake.
REQ-021 SHALL leave LOAD the cycle after the final handshake:
- to RUN if the latched run_cycles is nonzero;
- else to DONE.
The final imem_we coincides with that first post-LOAD cycle.
REQ-022 SHALL, in RUN, hold pipe_en=1 and increment cycles_run every cycle, entering DONE when cycles_run reaches the latched run_cycles.
REQ-023 SHALL, given REQ-022, produce exactly run_cycles cycles of pipe_en=1.
REQ-024 SHALL hold pipe_en=0 and imem_we=0 in every state other than RUN and LOAD+1 respectively.
REQ-025 SHALL drive busy=1 in CLR, LOAD, and RUN, and busy=0 otherwise.
REQ-026 SHALL drive done=1 in DONE, held until the next start or reset.
REQ-027 SHALL, on abort=1 in any state, enter IDLE next cycle, with the following outputs:
- pipe_en=0 and imem_we=0 from that cycle;
- done=0;
- cycles_run holding its value.
REQ-028 SHALL give abort priority when abort and start occur in the same cycle; the result is IDLE and no sequence starts.
REQ-029 SHALL ignore mid-sequence changes to prog_len and run_cycles; only the values latched at start are used.
REQ-030 SHALL saturate cycles_run at 2^32-1 and not wrap.

Reset
REQ-031 SHALL, with reset=1 at a clock edge, set the outputs and internal state as follows:
- state=IDLE;
- pipe_reset=0, pipe_en=0, imem_we=0, imem_addr=0, imem_data=0;
- ld_ready=0, busy=0, done=0, cycles_run=0;
- word index and latches cleared.
REQ-032 SHALL give reset priority over start and abort, and reset SHALL take effect from any state, including mid-LOAD and mid-RUN.

Verification
REQ-033 SHALL be verified with prog_len=3, run_cycles=5, start, and ld_valid held high with data A,B,C -> the following response:
- pipe_reset high 2 cycles;
- imem writes (0,A),(1,B),(2,C) on consecutive cycles;
- pipe_en high exactly 5 cycles;
- done=1, cycles_run=5.
REQ-034 SHALL be verified with prog_len=2 and ld_valid toggling 1,0,0,1 -> exactly 2 imem writes at addr 0 and 1, with no write on the gap cycles.
REQ-035 SHALL be verified with prog_len=0, run_cycles=0, and start -> CLR for 2 cycles then DONE, with no imem_we and no pipe_en.
REQ-036 SHALL be verified with abort pulsed on the 3rd RUN cycle -> the following response:
- pipe_en=0 the next cycle;
- state=IDLE, done=0, cycles_run=3.
REQ-037 SHALL be verified with start and abort in the same cycle from DONE -> state IDLE and busy never asserted.
REQ-038 SHALL be verified with reset asserted mid-LOAD after 1 of 4 words -> every output at its reset value the next cycle, and a subsequent start reloading from addr 0.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: sequences a pipeline through a 2-cycle clear, a streamed program load
// into instruction memory, and a timed run, with abort and status reporting.
module pipe_run_ctrl #(
    parameter int IMEM_AW = 9,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [IMEM_AW:0]   prog_len,
    input  logic [31:0]        run_cycles,
    input  logic               ld_valid,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               ld_ready,
    output logic               pipe_reset,
    output logic               pipe_en,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_data,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state,
    output logic [31:0]        cycles_run
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [IMEM_AW:0] MAX_LEN = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [IMEM_AW:0] ONE_W   = {{IMEM_AW{1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [IMEM_AW:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic [31:0]        rc_q, rc_d, cr_q, cr_d, cr_sat;
    logic               clr_q, clr_d;
    logic               we_q, we_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               pipe_reset_q, pipe_en_q, busy_q, done_q, ld_ready_q;
    logic               hs;

    // Stream handshake: a word transfers on a rising edge where ld_valid and ld_ready are
    // both high; ld_ready never depends on ld_valid, and ld_data is only sampled then.
    assign hs      = ld_valid & ld_ready_q;
    assign cnt_inc = cnt_q + ONE_W;
    assign cr_sat  = (cr_q == 32'hFFFF_FFFF) ? cr_q : cr_q + 32'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rc_d    = rc_q;
        cr_d    = cr_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (abort) begin
            // The RUN cycle in which abort arrives still ran, so it is counted.
            state_d = S_IDLE;
            if (state_q == S_RUN) cr_d = cr_sat;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_CLR;
                        len_d   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                        rc_d    = run_cycles;
                        cr_d    = 32'd0;
                        cnt_d   = '0;
                        clr_d   = 1'b0;
                    end
                end
                S_CLR: begin
                    if (clr_q) begin
                        if (len_q != '0)       state_d = S_LOAD;
                        else if (rc_q != 32'd0) state_d = S_RUN;
                        else                    state_d = S_DONE;
                    end else begin
                        clr_d = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        we_d   = 1'b1;
                        addr_d = cnt_q[IMEM_AW-1:0];
                        data_d = ld_data;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == len_q) state_d = (rc_q != 32'd0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    cr_d = cr_sat;
                    if (cr_sat == rc_q) state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            rc_q         <= 32'd0;
            cr_q         <= 32'd0;
            cnt_q        <= '0;
            clr_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            pipe_reset_q <= 1'b0;
            pipe_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ld_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rc_q         <= rc_d;
            cr_q         <= cr_d;
            cnt_q        <= cnt_d;
            clr_q        <= clr_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            pipe_reset_q <= (state_d == S_CLR);
            pipe_en_q    <= (state_d == S_RUN);
            busy_q       <= (state_d == S_CLR) || (state_d == S_LOAD) || (state_d == S_RUN);
            done_q       <= (state_d == S_DONE);
            ld_ready_q   <= (state_d == S_LOAD) && (cnt_d < len_d);
        end
    end

    assign state      = state_q;
    assign pipe_reset = pipe_reset_q;
    assign pipe_en    = pipe_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ld_ready   = ld_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_data  = data_q;
    assign cycles_run = cr_q;
endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: sequence-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized sequences.
module tb_pipe_run_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic [31:0]   run_cycles = 32'd0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready, pipe_reset, pipe_en, imem_we, busy, done;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic [2:0]    state;
    logic [31:0]   cycles_run;

    pipe_run_ctrl #(.IMEM_AW(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .prog_len(prog_len), .run_cycles(run_cycles),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .pipe_reset(pipe_reset), .pipe_en(pipe_en),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .busy(busy), .done(done), .state(state), .cycles_run(cycles_run)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase of the sequence plus plain counters, advanced per edge.
    int          m_mode = 0;
    int          m_len = 0, m_words = 0, m_clr = 0;
    longint      m_rc = 0, m_cr = 0;
    bit          m_zero = 1'b1;
    bit          live = 1'b0;
    logic [AW+DW-1:0] exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_len = 0; m_words = 0; m_clr = 0; m_rc = 0; m_cr = 0;
            m_zero = 1'b1; live = 1'b1;
            exp_q.delete();
        end else if (abort) begin
            if (m_mode == 3 && m_cr < 64'hFFFF_FFFF) m_cr++;
            m_mode = 0;
        end else begin
            case (m_mode)
                0, 4: if (start) begin
                    m_len = (int'(prog_len) > (1 << AW)) ? (1 << AW) : int'(prog_len);
                    m_rc = longint'(run_cycles); m_cr = 0; m_words = 0; m_clr = 0;
                    m_mode = 1;
                end
                1: begin
                    m_clr++;
                    if (m_clr == 2) m_mode = (m_len != 0) ? 2 : ((m_rc != 0) ? 3 : 4);
                end
                2: if (ld_valid && m_words < m_len) begin
                    exp_q.push_back({AW'(m_words), ld_data});
                    m_zero = 1'b0;
                    m_words++;
                    if (m_words == m_len) m_mode = (m_rc != 0) ? 3 : 4;
                end
                3: begin
                    if (m_cr < 64'hFFFF_FFFF) m_cr++;
                    if (m_cr >= m_rc) m_mode = 4;
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Observation logs for the directed literal checks.
    int cyc = 0, pr_cnt = 0, pe_cnt = 0;
    int wr_addr_q[$], wr_data_q[$], wr_t_q[$];

    always @(negedge clk) begin
        logic [AW+DW-1:0] w;
        cyc++;
        if (pipe_reset) pr_cnt++;
        if (pipe_en) pe_cnt++;
        if (imem_we) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(int'(imem_data));
            wr_t_q.push_back(cyc);
        end
        if (live) begin
            chk("state", state, m_mode);
            chk("pipe_reset", pipe_reset, m_mode == 1);
            chk("pipe_en", pipe_en, m_mode == 3);
            chk("busy", busy, m_mode >= 1 && m_mode <= 3);
            chk("done", done, m_mode == 4);
            chk("ld_ready", ld_ready, m_mode == 2 && m_words < m_len);
            chk("cycles_run", cycles_run, m_cr);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("imem_we", imem_we, 1);
                chk("imem_addr_data", {imem_addr, imem_data}, w);
            end else begin
                chk("imem_we", imem_we, 0);
            end
            if (m_zero) chk("imem_addr_data_rst", {imem_addr, imem_data}, 0);
        end
    end

    task automatic clear_logs();
        pr_cnt = 0; pe_cnt = 0;
        wr_addr_q.delete(); wr_data_q.delete(); wr_t_q.delete();
    endtask

    // vmode 0: valid held high; 1: valid 1,0,0,1 over LOAD cycles; else random.
    task automatic run_seq(input int len, input int rc, input int vmode, input int abort_pe,
                           input bit noise);
        int idx, j, k, pe_seen;
        bit fin;
        idx = 0; j = 0; k = 0; pe_seen = 0; fin = 1'b0;
        @(negedge clk);
        start = 1'b1; prog_len = LW'(len); run_cycles = rc; ld_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin && k < 300) begin
            if (pipe_en) pe_seen++;
            abort = (abort_pe > 0) && pipe_en && (pe_seen == abort_pe);
            if (noise) begin
                if ($urandom_range(0, 24) == 0) abort = 1'b1;
                start = busy && ($urandom_range(0, 5) == 0);
                prog_len = LW'($urandom_range(0, 31));
                run_cycles = $urandom_range(0, 40);
            end
            case (vmode)
                0: ld_valid = 1'b1;
                1: begin
                    ld_valid = ld_ready && (j == 0 || j == 3);
                    if (ld_ready) j++;
                end
                default: ld_valid = ($urandom_range(0, 1) == 1);
            endcase
            ld_data = DW'(32'hA000 + idx);
            if (ld_valid && ld_ready && !abort) idx++;
            @(negedge clk);
            k++;
            if (!busy) fin = 1'b1;
        end
        start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
        chk("seq_terminated", fin, 1);
        #1;
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cycles_run", cycles_run, 0);

        // Nominal: 3 words A,B,C, 5 run cycles.
        clear_logs();
        run_seq(3, 5, 0, 0, 1'b0);
        chk("t1_pipe_reset_cycles", pr_cnt, 2);
        chk("t1_write_count", wr_addr_q.size(), 3);
        if (wr_addr_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t1_addr", wr_addr_q[i], i);
                chk("t1_data", wr_data_q[i], 32'hA000 + i);
            end
            chk("t1_consec1", wr_t_q[1] - wr_t_q[0], 1);
            chk("t1_consec2", wr_t_q[2] - wr_t_q[1], 1);
        end
        chk("t1_pipe_en_cycles", pe_cnt, 5);
        chk("t1_done", done, 1);
        chk("t1_cycles_run", cycles_run, 5);

        // start + abort together from DONE: abort wins, nothing starts.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; prog_len = 3; run_cycles = 5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_state_idle", state, 0);
            chk("t2_busy_low", busy, 0);
            chk("t2_done_low", done, 0);
            @(negedge clk);
        end

        // Gapped load: valid 1,0,0,1.
        clear_logs();
        run_seq(2, 1, 1, 0, 1'b0);
        chk("t3_write_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            chk("t3_addr0", wr_addr_q[0], 0);
            chk("t3_addr1", wr_addr_q[1], 1);
            chk("t3_gap", wr_t_q[1] - wr_t_q[0], 3);
        end

        // Empty program and zero run.
        clear_logs();
        run_seq(0, 0, 0, 0, 1'b0);
        chk("t4_pipe_reset_cycles", pr_cnt, 2);
        chk("t4_writes", wr_addr_q.size(), 0);
        chk("t4_pipe_en", pe_cnt, 0);
        chk("t4_state_done", state, 4);

        // Abort on the 3rd RUN cycle.
        clear_logs();
        run_seq(2, 8, 0, 3, 1'b0);
        chk("t5_pipe_en_cycles", pe_cnt, 3);
        chk("t5_pipe_en_off", pipe_en, 0);
        chk("t5_state", state, 0);
        chk("t5_done", done, 0);
        chk("t5_cycles_run", cycles_run, 3);

        // Length above the memory size is clamped.
        clear_logs();
        run_seq(20, 2, 0, 0, 1'b0);
        chk("t6_write_count", wr_addr_q.size(), 16);
        if (wr_addr_q.size() == 16) chk("t6_last_addr", wr_addr_q[15], 15);

        // Reset mid-LOAD after one of four words, then a clean reload.
        clear_logs();
        @(negedge clk);
        start = 1'b1; prog_len = 4; run_cycles = 3;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!ld_ready && k < 10) begin @(negedge clk); k++; end
        chk("t7_ready_seen", ld_ready, 1);
        ld_valid = 1'b1; ld_data = 16'hB000;
        @(negedge clk);
        ld_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t7_one_write", wr_addr_q.size(), 1);
        chk("t7_state", state, 0);
        chk("t7_outs", {pipe_reset, pipe_en, imem_we, ld_ready, busy, done}, 0);
        chk("t7_addr_data", {imem_addr, imem_data}, 0);
        chk("t7_cycles_run", cycles_run, 0);
        clear_logs();
        run_seq(4, 3, 0, 0, 1'b0);
        chk("t7_reload_count", wr_addr_q.size(), 4);
        if (wr_addr_q.size() == 4) chk("t7_reload_addr0", wr_addr_q[0], 0);

        // Randomized sequences with mid-sequence input noise and aborts.
        for (int it = 0; it < 40; it++) begin
            run_seq($urandom_range(0, 20), $urandom_range(0, 12),
                    ($urandom_range(0, 1) == 1) ? 2 : 0, 0, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
